sram_rr_arb_ctrl: RTL and testbench

Round-robin controller sharing one single-port 64x15 fakeram45 macro between two requesters (port 0, port 1). Each requester has a valid/ready request channel for masked writes and reads, plus a valid/ready read-response channel with its own holding register. The block sits between two client pipelines and the SRAM macro. It drives the macro's ce/we/addr/wd/mask pins and never lets them go X.

---
 rtl/sram_rr_arb_ctrl_pkg.sv | 23 ++
 rtl/sram_rr_arb_ctrl_if.sv | 27 ++
 rtl/sram_rr_arb_ctrl_rr_arb2.sv | 30 +++
 rtl/sram_rr_arb_ctrl.sv | 140 ++++++++++++++
 tb/tb_sram_rr_arb_ctrl.sv | 304 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/sram_rr_arb_ctrl_pkg.sv
// Shared types for the two-port round-robin SRAM controller:
// the SRAM command bundle and the controller state encoding.
package sram_rr_arb_pkg;

    // Geometry of the fakeram45 64x15 macro this controller targets.
    localparam int unsigned PKG_DATA_W = 15;
    localparam int unsigned PKG_ADDR_W = 6;

    typedef enum logic {
        ST_INIT,
        ST_RUN
    } state_e;

    // One SRAM access as presented on the macro pins.
    typedef struct packed {
        logic                  ce;
        logic                  we;
        logic [PKG_ADDR_W-1:0] addr;
        logic [PKG_DATA_W-1:0] wd;
        logic [PKG_DATA_W-1:0] wmask;
    } ram_cmd_s;

endpackage

// File: rtl/sram_rr_arb_ctrl_if.sv
// Client-side bus of sram_rr_arb_ctrl: two request channels (masked
// write / read) and two read-response channels, packed per port.
// master = client pipelines, slave = controller.
interface sram_rr_arb_ctrl_if #(
    parameter int unsigned DATA_W = 15,
    parameter int unsigned ADDR_W = 6
);
    logic [1:0]          req_v_i;
    logic [1:0]          req_ready_o;
    logic [1:0]          req_we_i;
    logic [2*ADDR_W-1:0] req_addr_i;
    logic [2*DATA_W-1:0] req_data_i;
    logic [2*DATA_W-1:0] req_mask_i;
    logic [1:0]          resp_v_o;
    logic [1:0]          resp_ready_i;
    logic [2*DATA_W-1:0] resp_data_o;

    modport master (
        output req_v_i, req_we_i, req_addr_i, req_data_i, req_mask_i, resp_ready_i,
        input  req_ready_o, resp_v_o, resp_data_o
    );

    modport slave (
        input  req_v_i, req_we_i, req_addr_i, req_data_i, req_mask_i, resp_ready_i,
        output req_ready_o, resp_v_o, resp_data_o
    );
endinterface

// File: rtl/sram_rr_arb_ctrl_rr_arb2.sv
// rr_arb2: two-input round-robin arbiter. The pointer names the preferred
// port; the other port is granted only when the preferred one cannot go.
// The pointer moves to the non-granted port after every grant.
module rr_arb2 (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] eligible,
    output logic [1:0] grant
);
    logic ptr;

    // One-hot grant: preferred port first, otherwise the other one.
    always_comb begin
        grant = '0;
        if (eligible[ptr]) begin
            grant[ptr] = 1'b1;
        end else if (eligible[!ptr]) begin
            grant[!ptr] = 1'b1;
        end
    end

    // After an accept, prefer the port that was not served; hold otherwise.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr <= 1'b0;
        end else if (|grant) begin
            ptr <= grant[0];
        end
    end
endmodule

// File: rtl/sram_rr_arb_ctrl.sv
// sram_rr_arb_ctrl: shares one single-port 64x15 SRAM macro between two
// requesters with round-robin arbitration, masked writes and per-port
// read-response holding registers (2-cycle read latency).
// Optional build macro SRAM_RR_ARB_MEM_INIT_EN: zero-fill the whole macro
// after every reset before accepting requests.
module sram_rr_arb_ctrl
    import sram_rr_arb_pkg::*;
#(
    parameter int unsigned DATA_W = 15,
    parameter int unsigned ADDR_W = 6,
    parameter int unsigned DEPTH  = 64
) (
    input  logic               clk,
    input  logic               rst_n,
    sram_rr_arb_ctrl_if.slave  bus,
    output logic               init_done_o,
    output logic               ram_ce_o,
    output logic               ram_we_o,
    output logic [ADDR_W-1:0]  ram_addr_o,
    output logic [DATA_W-1:0]  ram_wd_o,
    output logic [DATA_W-1:0]  ram_wmask_o,
    input  logic [DATA_W-1:0]  ram_rd_i
);
    if (DEPTH != (1 << ADDR_W)) begin : g_bad_depth
        $error("DEPTH must equal 2**ADDR_W");
    end

    logic [1:0]          inflight;
    logic [1:0]          resp_v;
    logic [2*DATA_W-1:0] resp_data;
    logic [1:0]          eligible;
    logic [1:0]          grant;
    logic                gsel;
    logic                init_done;
    logic                init_wr;
    logic [ADDR_W-1:0]   init_addr;
    ram_cmd_s            cmd;

`ifdef SRAM_RR_ARB_MEM_INIT_EN
    state_e state;

    // Sweep zeros through every word once after reset, then open the ports.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_INIT;
            init_addr <= '0;
            init_done <= 1'b0;
        end else if (state == ST_INIT) begin
            init_addr <= init_addr + ADDR_W'(1);
            if (init_addr == ADDR_W'(DEPTH - 1)) begin
                state     <= ST_RUN;
                init_done <= 1'b1;
            end
        end
    end

    // Gated by rst_n so the macro pins stay quiet while reset is held.
    assign init_wr = (state == ST_INIT) && rst_n;
`else
    // Usable from the first cycle after reset release.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            init_done <= 1'b0;
        end else begin
            init_done <= 1'b1;
        end
    end

    assign init_wr   = 1'b0;
    assign init_addr = '0;
`endif

    // A port may go when the SRAM is up and, for reads, its response slot will be free.
    always_comb begin
        eligible = '0;
        for (int unsigned p = 0; p < 2; p++) begin
            eligible[p] = init_done && bus.req_v_i[p] &&
                          (bus.req_we_i[p] ||
                           (!inflight[p] && (!resp_v[p] || bus.resp_ready_i[p])));
        end
    end

    rr_arb2 u_arb (
        .clk      (clk),
        .rst_n    (rst_n),
        .eligible (eligible),
        .grant    (grant)
    );

    assign gsel = grant[1];

    // Macro command: init sweep, else the granted request, else all zeros.
    always_comb begin
        cmd = '0;
        if (init_wr) begin
            cmd.ce    = 1'b1;
            cmd.we    = 1'b1;
            cmd.addr  = init_addr;
            cmd.wmask = '1;
        end else if (|grant) begin
            cmd.ce    = 1'b1;
            cmd.we    = gsel ? bus.req_we_i[1] : bus.req_we_i[0];
            cmd.addr  = gsel ? bus.req_addr_i[2*ADDR_W-1:ADDR_W] : bus.req_addr_i[ADDR_W-1:0];
            cmd.wd    = gsel ? bus.req_data_i[2*DATA_W-1:DATA_W] : bus.req_data_i[DATA_W-1:0];
            cmd.wmask = gsel ? bus.req_mask_i[2*DATA_W-1:DATA_W] : bus.req_mask_i[DATA_W-1:0];
        end
    end

    assign ram_ce_o    = cmd.ce;
    assign ram_we_o    = cmd.we;
    assign ram_addr_o  = cmd.addr;
    assign ram_wd_o    = cmd.wd;
    assign ram_wmask_o = cmd.wmask;

    // Capture read data the cycle after the access; hold until the client takes it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            inflight  <= '0;
            resp_v    <= '0;
            resp_data <= '0;
        end else begin
            for (int unsigned p = 0; p < 2; p++) begin
                if (inflight[p]) begin
                    resp_data[p*DATA_W +: DATA_W] <= ram_rd_i;
                    resp_v[p]                     <= 1'b1;
                end else if (bus.resp_ready_i[p]) begin
                    resp_v[p] <= 1'b0;
                end
                // A port with a read in flight can only be granted a write,
                // so this both sets and clears the flag.
                inflight[p] <= grant[p] && !bus.req_we_i[p];
            end
        end
    end

    assign bus.req_ready_o = grant;
    assign bus.resp_v_o    = resp_v;
    assign bus.resp_data_o = resp_data;
    assign init_done_o     = init_done;
endmodule

// File: tb/tb_sram_rr_arb_ctrl.sv
// Self-checking bench for sram_rr_arb_ctrl: directed scenarios plus
// randomized traffic, with a shadow-memory reference model feeding
// per-port expected-response queues and a negedge monitor.
`timescale 1ns/1ps
module tb_sram_rr_arb_ctrl;
    localparam int unsigned DATA_W = 15;
    localparam int unsigned ADDR_W = 6;
    localparam int unsigned DEPTH  = 64;
`ifdef SRAM_RR_ARB_MEM_INIT_EN
    localparam int INIT_CYCLES = 64;
`else
    localparam int INIT_CYCLES = 1;
`endif

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              init_done;
    logic              ram_ce, ram_we;
    logic [ADDR_W-1:0] ram_addr;
    logic [DATA_W-1:0] ram_wd, ram_wmask;
    logic [DATA_W-1:0] ram_rd = '0;

    sram_rr_arb_ctrl_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();

    sram_rr_arb_ctrl #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .bus         (bus),
        .init_done_o (init_done),
        .ram_ce_o    (ram_ce),
        .ram_we_o    (ram_we),
        .ram_addr_o  (ram_addr),
        .ram_wd_o    (ram_wd),
        .ram_wmask_o (ram_wmask),
        .ram_rd_i    (ram_rd)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Behavioural SRAM macro; read data is garbage except after a read.
    logic [DATA_W-1:0] macro_mem [DEPTH] = '{default: '0};
    always @(posedge clk) begin
        if (ram_ce && ram_we)
            macro_mem[ram_addr] <= (ram_wd & ram_wmask) | (macro_mem[ram_addr] & ~ram_wmask);
        if (ram_ce && !ram_we) ram_rd <= macro_mem[ram_addr];
        else                   ram_rd <= DATA_W'($urandom);
    end

    // Reference model: memory image as seen by accepted requests, in accept order.
    logic [DATA_W-1:0] shadow [DEPTH] = '{default: '0};
    logic [DATA_W-1:0] q0 [$];
    logic [DATA_W-1:0] q1 [$];

    int total = 0;
    int bad = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor: scoreboard update on accepts, response pops, pin and hold checks.
    logic [1:0]          prev_hold = '0;
    logic [2*DATA_W-1:0] prev_data = '0;
    always @(negedge clk) begin
        logic [1:0]        acc;
        int                gp;
        logic [ADDR_W-1:0] a;
        logic [DATA_W-1:0] d, m, got, exp;
        check("ram_pins_known", 64'($isunknown({ram_ce, ram_we, ram_addr, ram_wd, ram_wmask})), 64'd0);
        if (!rst_n) begin
            check("ram_pins_in_reset", 64'({ram_ce, ram_we, ram_addr, ram_wd, ram_wmask}), 64'd0);
            prev_hold = '0;
        end else begin
            acc = bus.req_v_i & bus.req_ready_o;
            check("ready_onehot", 64'(bus.req_ready_o == 2'b11), 64'd0);
            check("ready_without_valid", 64'(|(bus.req_ready_o & ~bus.req_v_i)), 64'd0);
            if (!init_done) begin
                check("ready_before_init", 64'(bus.req_ready_o), 64'd0);
            end else begin
                if (|(bus.req_v_i & bus.req_we_i))
                    check("write_never_blocked", 64'(|bus.req_ready_o), 64'd1);
                if (acc != 2'b00) begin
                    gp = acc[1] ? 1 : 0;
                    a = bus.req_addr_i[gp*ADDR_W +: ADDR_W];
                    d = bus.req_data_i[gp*DATA_W +: DATA_W];
                    m = bus.req_mask_i[gp*DATA_W +: DATA_W];
                    check("ram_cmd_grant", 64'({ram_ce, ram_we, ram_addr, ram_wd, ram_wmask}),
                          64'({1'b1, bus.req_we_i[gp], a, d, m}));
                    if (bus.req_we_i[gp]) begin
                        shadow[a] = (d & m) | (shadow[a] & ~m);
                    end else if (gp == 0) begin
                        q0.push_back(shadow[a]);
                    end else begin
                        q1.push_back(shadow[a]);
                    end
                end else begin
                    check("ram_cmd_idle", 64'({ram_ce, ram_we, ram_addr, ram_wd, ram_wmask}), 64'd0);
                end
            end
            for (int p = 0; p < 2; p++) begin
                got = bus.resp_data_o[p*DATA_W +: DATA_W];
                if (prev_hold[p]) begin
                    check("resp_hold_valid", 64'(bus.resp_v_o[p]), 64'd1);
                    check("resp_hold_data", 64'(got), 64'(prev_data[p*DATA_W +: DATA_W]));
                end
                if (bus.resp_v_o[p] && bus.resp_ready_i[p]) begin
                    if ((p == 0 ? q0.size() : q1.size()) == 0) begin
                        check("resp_unexpected", 64'(p), 64'hFF);
                    end else begin
                        exp = (p == 0) ? q0.pop_front() : q1.pop_front();
                        check("resp_data", 64'(got), 64'(exp));
                    end
                end
            end
            prev_hold = bus.resp_v_o & ~bus.resp_ready_i;
            prev_data = bus.resp_data_o;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int p, input logic v, input logic we, input logic [ADDR_W-1:0] a,
                           input logic [DATA_W-1:0] d, input logic [DATA_W-1:0] m);
        bus.req_v_i[p] = v;
        bus.req_we_i[p] = we;
        bus.req_addr_i[p*ADDR_W +: ADDR_W] = a;
        bus.req_data_i[p*DATA_W +: DATA_W] = d;
        bus.req_mask_i[p*DATA_W +: DATA_W] = m;
    endtask

    // Issue one request and wait (bounded) for its accept; returns accept cycle.
    task automatic do_req(input int p, input logic we, input logic [ADDR_W-1:0] a,
                          input logic [DATA_W-1:0] d, input logic [DATA_W-1:0] m, output int acc_cyc);
        int n = 0;
        acc_cyc = -1;
        set_req(p, 1'b1, we, a, d, m);
        while (acc_cyc < 0 && n < 100) begin
            @(negedge clk);
            if (bus.req_ready_o[p]) acc_cyc = cyc;
            n++;
            step();
        end
        bus.req_v_i[p] = 1'b0;
        if (acc_cyc < 0) check("req_accept_timeout", 64'(p), 64'hFF);
    endtask

    task automatic wait_resp(input int p, output int seen_cyc, output logic [DATA_W-1:0] data);
        int n = 0;
        seen_cyc = -1;
        data = '0;
        while (seen_cyc < 0 && n < 50) begin
            @(negedge clk);
            if (bus.resp_v_o[p]) begin
                seen_cyc = cyc;
                data = bus.resp_data_o[p*DATA_W +: DATA_W];
            end
            n++;
        end
        if (seen_cyc < 0) check("resp_timeout", 64'(p), 64'hFF);
        step();
    endtask

    task automatic do_reset();
        int n = 0;
        rst_n = 1'b0;
        q0.delete();
        q1.delete();
`ifdef SRAM_RR_ARB_MEM_INIT_EN
        for (int i = 0; i < DEPTH; i++) shadow[i] = '0;
`endif
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        while (!init_done && n < 200) begin
            step();
            n++;
        end
        check("init_latency", 64'(n), 64'(INIT_CYCLES));
    endtask

    initial begin
        #500000;
        bad++;
        $display("FAIL global_timeout: simulation did not complete");
        $display("test done: total=%0d bad=%0d", total, bad);
        $fatal(1, "timeout");
    end

    initial begin
        int c, rc;
        logic [DATA_W-1:0] rd;
        logic [1:0] acc;

        bus.req_v_i = '0;
        bus.req_we_i = '0;
        bus.req_addr_i = '0;
        bus.req_data_i = '0;
        bus.req_mask_i = '0;
        bus.resp_ready_i = 2'b11;
        #3;
        check("reset_resp_v", 64'(bus.resp_v_o), 64'd0);
        check("reset_resp_data", 64'(bus.resp_data_o), 64'd0);
        check("reset_ready", 64'(bus.req_ready_o), 64'd0);
        do_reset();

        // Untouched word reads back zero.
        do_req(0, 1'b0, 6'd37, '0, '0, c);
        wait_resp(0, rc, rd);
        check("addr37_zero", 64'(rd), 64'h0);

        // Write then read on port 0, 2-cycle latency.
        do_req(0, 1'b1, 6'd5, 15'h1234, 15'h7FFF, c);
        do_req(0, 1'b0, 6'd5, '0, '0, c);
        wait_resp(0, rc, rd);
        check("read_latency", 64'(rc - c), 64'd2);
        check("addr5_data", 64'(rd), 64'h1234);

        // Partial mask on port 1.
        do_req(1, 1'b1, 6'd9, 15'h7FFF, 15'h7FFF, c);
        do_req(1, 1'b1, 6'd9, 15'h0000, 15'h00FF, c);
        do_req(1, 1'b0, 6'd9, '0, '0, c);
        wait_resp(1, rc, rd);
        check("partial_mask", 64'(rd), 64'h7F00);

        // Both ports writing every cycle: grants alternate from port 0.
        do_reset();
        for (int k = 0; k < 8; k++) begin
            set_req(0, 1'b1, 1'b1, 6'($urandom_range(0, 63)), DATA_W'($urandom), '1);
            set_req(1, 1'b1, 1'b1, 6'($urandom_range(0, 63)), DATA_W'($urandom), '1);
            @(negedge clk);
            check("alternate_grant", 64'(bus.req_ready_o), (k % 2 == 0) ? 64'd1 : 64'd2);
            step();
        end
        bus.req_v_i = '0;

        // Port 1 response back-pressured; second read blocked, port 0 free.
        do_req(0, 1'b1, 6'd63, 15'h5A3C, 15'h7FFF, c);
        bus.resp_ready_i[1] = 1'b0;
        do_req(1, 1'b0, 6'd63, '0, '0, c);
        set_req(1, 1'b1, 1'b0, 6'd9, '0, '0);
        for (int k = 0; k < 10; k++) begin
            set_req(0, 1'b1, 1'b1, 6'($urandom_range(20, 30)), DATA_W'($urandom), DATA_W'($urandom));
            @(negedge clk);
            check("blocked_port1_ready", 64'(bus.req_ready_o), 64'd1);
            step();
        end
        bus.resp_ready_i[1] = 1'b1;
        @(negedge clk);
        check("port1_released", 64'(bus.req_ready_o), 64'd2);
        step();
        bus.req_v_i = '0;
        repeat (4) step();

        // Reset with a read in flight: response discarded.
        do_req(0, 1'b0, 6'd5, '0, '0, c);
        #1 rst_n = 1'b0;
        #1;
        check("async_reset_resp_v", 64'(bus.resp_v_o), 64'd0);
        check("async_reset_pins", 64'({ram_ce, ram_we, ram_addr, ram_wd, ram_wmask}), 64'd0);
        do_reset();
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            check("no_resp_after_reset", 64'(bus.resp_v_o), 64'd0);
            step();
        end

        // Randomized traffic on a small address window.
        acc = '0;
        for (int k = 0; k < 800; k++) begin
            @(negedge clk);
            acc = bus.req_v_i & bus.req_ready_o;
            step();
            for (int p = 0; p < 2; p++) begin
                if (!bus.req_v_i[p] || acc[p]) begin
                    if ($urandom_range(0, 3) != 0)
                        set_req(p, 1'b1, 1'($urandom_range(0, 1)), 6'($urandom_range(0, 7)),
                                DATA_W'($urandom),
                                ($urandom_range(0, 1) != 0) ? '1 : DATA_W'($urandom));
                    else
                        bus.req_v_i[p] = 1'b0;
                end
                bus.resp_ready_i[p] = ($urandom_range(0, 3) != 0);
            end
        end

        bus.req_v_i = '0;
        bus.resp_ready_i = 2'b11;
        repeat (10) step();
        check("drain_q0", 64'(q0.size()), 64'd0);
        check("drain_q1", 64'(q1.size()), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
